// File: rtl/tmp101_pkg.sv
// Shared constants for the TMP101 target emulation.
//   TMP101_BASE_ADDR : fixed upper four bits of the 7-bit bus address
//   PTR_*            : pointer register encodings
//   state_e          : protocol FSM states of the responder
package tmp101_pkg;

  localparam logic [3:0] TMP101_BASE_ADDR = 4'b1001;

  localparam logic [1:0] PTR_TEMP  = 2'd0;
  localparam logic [1:0] PTR_CONF  = 2'd1;
  localparam logic [1:0] PTR_TLOW  = 2'd2;
  localparam logic [1:0] PTR_THIGH = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one open-drain bus line: a 2-flop synchronizer followed by a
// glitch filter whose output only follows the input after FILTER_LEN
// consecutive samples at the new level.
//   clk, reset_n : system clock, synchronous active-low reset
//   raw          : asynchronous line level from the pad
//   level        : synchronized, filtered level (resets to the idle-high value)
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tmp101_i2c_responder.sv
// I2C target emulating a TMP101 at address {4'b1001, I2C_ADDR}.
//   clk, reset_n      : system clock, synchronous active-low reset
//   ena               : 0 = never ACK, ignore the bus
//   temperature       : 12-bit two's complement value served at pointer 0
//   pointer           : current pointer register
//   config_reg        : configuration register (pointer 1)
//   tlow, thigh       : TLOW[15:4], THIGH[15:4]
//   status            : {bus_busy, selected, xfer_done}
//   sda_t/sda_i       : SDA open-drain control (0 pulls low) and level
//   scl_t/scl_i       : SCL control (always released) and level
module tmp101_i2c_responder
  import tmp101_pkg::*;
#(
  parameter logic [2:0]  I2C_ADDR   = 3'd0,
  parameter int          FILTER_LEN = 4,
  parameter logic [11:0] TLOW_RST   = 12'h4B0,
  parameter logic [11:0] THIGH_RST  = 12'h500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ena,
  input  logic [11:0] temperature,
  output logic [1:0]  pointer,
  output logic [7:0]  config_reg,
  output logic [11:0] tlow,
  output logic [11:0] thigh,
  output logic [2:0]  status,
  output logic        sda_t,
  input  logic        sda_i,
  output logic        scl_t,
  input  logic        scl_i
);

  logic   scl_f, sda_f, scl_q, sda_q;
  logic   scl_rise, scl_fall, start_cond, stop_cond;
  state_e state, state_d;
  logic [3:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] rx_byte, rd_shift, tx_byte;
  logic [3:0] temp_lsb;
  logic       rd_mode, first_wr, msb_phase;
  logic       bus_busy, selected, xfer_done;
  logic       addr_hit, load_byte;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk), .reset_n(reset_n), .raw(scl_i), .level(scl_f)
  );
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk), .reset_n(reset_n), .raw(sda_i), .level(sda_f)
  );

  assign scl_t      = 1'b1;
  assign status     = {bus_busy, selected, xfer_done};
  assign scl_rise   = scl_f & ~scl_q;
  assign scl_fall   = ~scl_f & scl_q;
  assign start_cond = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_cond  = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_byte    = {shreg, sda_f};
  assign addr_hit   = ena && (rx_byte[7:1] == {TMP101_BASE_ADDR, I2C_ADDR});

  // A new read byte is fetched when the address ACK slot ends in read mode,
  // or when the master ACKs the previous byte.
  assign load_byte = (state == ST_ADDR_ACK && scl_fall && !sda_t && rd_mode) ||
                     (state == ST_RD_ACK && scl_rise && !sda_f);

  // Byte presented for the next read; two-byte registers are left aligned.
  always_comb begin
    tx_byte = config_reg;
    case (pointer)
      PTR_TEMP:  tx_byte = msb_phase ? temperature[11:4] : {temp_lsb, 4'b0};
      PTR_TLOW:  tx_byte = msb_phase ? tlow[11:4]        : {tlow[3:0], 4'b0};
      PTR_THIGH: tx_byte = msb_phase ? thigh[11:4]       : {thigh[3:0], 4'b0};
      default:   tx_byte = config_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    if (start_cond) begin
      state_d = ST_ADDR;
    end else if (stop_cond) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR:     if (scl_rise && bit_cnt == 4'd7)
                       state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK: if (scl_fall && !sda_t)
                       state_d = rd_mode ? ST_RD_BYTE : ST_WR_BYTE;
        ST_WR_BYTE:  if (scl_rise && bit_cnt == 4'd7)
                       state_d = ena ? ST_WR_ACK : ST_IGNORE;
        ST_WR_ACK:   if (scl_fall && !sda_t) state_d = ST_WR_BYTE;
        ST_RD_BYTE:  if (scl_fall && bit_cnt == 4'd8) state_d = ST_RD_ACK;
        ST_RD_ACK:   if (scl_rise) state_d = sda_f ? ST_IGNORE : ST_RD_BYTE;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      sda_t      <= 1'b1;
      bit_cnt    <= '0;
      shreg      <= '0;
      rd_shift   <= '0;
      temp_lsb   <= '0;
      rd_mode    <= 1'b0;
      first_wr   <= 1'b1;
      msb_phase  <= 1'b1;
      bus_busy   <= 1'b0;
      selected   <= 1'b0;
      xfer_done  <= 1'b0;
      pointer    <= PTR_TEMP;
      config_reg <= 8'h00;
      tlow       <= TLOW_RST;
      thigh      <= THIGH_RST;
    end else begin
      scl_q     <= scl_f;
      sda_q     <= sda_f;
      xfer_done <= 1'b0;
      if (start_cond) begin
        bus_busy  <= 1'b1;
        sda_t     <= 1'b1;
        bit_cnt   <= '0;
        first_wr  <= 1'b1;
        msb_phase <= 1'b1;
      end else if (stop_cond) begin
        bus_busy  <= 1'b0;
        sda_t     <= 1'b1;
        xfer_done <= selected;
        selected  <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg <= rx_byte[6:0];
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              rd_mode <= rx_byte[0];
              if (addr_hit) selected <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          // sda_t doubles as the ACK phase marker: the first falling edge
          // pulls SDA low, the second ends the ACK slot.
          ST_ADDR_ACK: if (scl_fall) begin
            if (sda_t) begin
              sda_t <= 1'b0;
            end else if (rd_mode) begin
              sda_t    <= tx_byte[7];
              rd_shift <= {tx_byte[6:0], 1'b0};
              bit_cnt  <= 4'd1;
            end else begin
              sda_t <= 1'b1;
            end
          end
          ST_WR_BYTE: if (scl_rise) begin
            shreg <= rx_byte[6:0];
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (ena && first_wr) begin
                pointer  <= rx_byte[1:0];
                first_wr <= 1'b0;
              end else if (ena) begin
                case (pointer)
                  PTR_CONF: config_reg <= rx_byte;
                  PTR_TLOW: begin
                    if (msb_phase) tlow[11:4] <= rx_byte;
                    else           tlow[3:0]  <= rx_byte[7:4];
                    msb_phase <= ~msb_phase;
                  end
                  PTR_THIGH: begin
                    if (msb_phase) thigh[11:4] <= rx_byte;
                    else           thigh[3:0]  <= rx_byte[7:4];
                    msb_phase <= ~msb_phase;
                  end
                  default: ;
                endcase
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ST_WR_ACK: if (scl_fall) sda_t <= ~sda_t;
          // Data bits are placed on SDA after each falling edge: release for
          // a 1, pull low for a 0. After bit 0 the line is freed for the ACK.
          ST_RD_BYTE: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_t   <= 1'b1;
              bit_cnt <= '0;
            end else begin
              sda_t    <= rd_shift[7];
              rd_shift <= {rd_shift[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end
          ST_RD_ACK: if (scl_rise && !sda_f) begin
            rd_shift <= tx_byte;
            bit_cnt  <= '0;
          end
          default: sda_t <= 1'b1;
        endcase
        if (load_byte) begin
          // Freeze the low nibble with the MSB so both bytes are coherent.
          if (pointer == PTR_TEMP && msb_phase) temp_lsb <= temperature[3:0];
          if (pointer != PTR_CONF) msb_phase <= ~msb_phase;
        end
      end
    end
  end

endmodule

// File: tb/tb_tmp101_i2c_responder.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// (LSB snapshot, SCL glitch, reset mid-read) and randomized transactions
// checked against a register-image reference model.
module tb_tmp101_i2c_responder;

  localparam int         Q   = 10;      // clk cycles per SCL quarter period
  localparam logic [6:0] DEV = 7'h48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, ena;
  logic [11:0] temperature;
  logic [1:0]  pointer;
  logic [7:0]  config_reg;
  logic [11:0] tlow, thigh;
  logic [2:0]  status;
  logic        sda_t, scl_t, sda_i, scl_i;
  logic        m_sda = 1'b1, m_scl = 1'b1, scl_glitch = 1'b0;

  assign sda_i = m_sda & sda_t;
  assign scl_i = (m_scl & scl_t) ^ scl_glitch;

  tmp101_i2c_responder dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .temperature(temperature),
    .pointer(pointer), .config_reg(config_reg), .tlow(tlow), .thigh(thigh),
    .status(status), .sda_t(sda_t), .sda_i(sda_i), .scl_t(scl_t), .scl_i(scl_i)
  );

  int checks = 0, failures = 0;
  int done_total = 0, low_total = 0, sel_total = 0;

  always @(posedge clk) begin
    if (status[0]) done_total <= done_total + 1;
    if (!sda_t)    low_total  <= low_total + 1;
    if (status[1]) sel_total  <= sel_total + 1;
  end

  logic [7:0] wbuf[4];
  logic [7:0] rbuf[4];
  logic       addr_ack, bytes_acked;
  logic       swap_armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    m_sda = b;
    if (glitch) begin
      repeat (3) @(negedge clk);
      scl_glitch = 1'b1;
      @(negedge clk);
      scl_glitch = 1'b0;
      repeat (Q - 4) @(negedge clk);
    end else begin
      wait_q();
    end
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    b = sda_i;    wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] v, output logic nack);
    for (int i = 7; i >= 0; i--) write_bit(v[i], 1'b0);
    read_bit(nack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic last);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
      if (swap_armed && i == 4) begin
        temperature = 12'h7FF;
        swap_armed  = 1'b0;
      end
    end
    write_bit(last, 1'b0);
  endtask

  // Optional write phase, optional repeated-START read phase, then STOP.
  task automatic xfer(input logic [6:0] a7, input int nw, input int nr);
    logic nk;
    logic [7:0] b;
    addr_ack = 1'b1;
    bytes_acked = 1'b1;
    if (nw > 0) begin
      i2c_start();
      write_byte({a7, 1'b0}, nk);
      if (nk) addr_ack = 1'b0;
      for (int j = 0; j < nw; j++) begin
        write_byte(wbuf[j], nk);
        if (nk) bytes_acked = 1'b0;
      end
    end
    if (nr > 0) begin
      i2c_start();
      write_byte({a7, 1'b1}, nk);
      if (nk) addr_ack = 1'b0;
      for (int j = 0; j < nr; j++) begin
        read_byte(b, j == nr - 1);
        rbuf[j] = b;
      end
    end
    i2c_stop();
    wait_q();
  endtask

  // Reference model: two-byte registers are 16-bit images {reg, 4'b0}
  // accessed big-endian, alternating MSB/LSB from the first data byte.
  function automatic logic [7:0] img_byte(input logic [11:0] r, input int i);
    logic [15:0] img;
    img = {r, 4'b0};
    return (i % 2 == 0) ? img[15:8] : img[7:0];
  endfunction

  function automatic logic [11:0] img_write(input logic [11:0] r, input int k, input logic [7:0] b);
    logic [15:0] img;
    img = {r, 4'b0};
    if (k % 2 == 0) img[15:8] = b;
    else            img[7:0]  = b;
    return img[15:4];
  endfunction

  typedef struct {
    string       name;
    logic [6:0]  addr;
    int          nw;
    logic [7:0]  w0, w1, w2;
    int          nr;
    logic [11:0] temp;
    logic        exp_ack;
    logic [7:0]  exp_r0, exp_r1;
    logic [7:0]  exp_conf;
    logic [11:0] exp_thigh;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, l0, s0;
    logic nk;
    logic [7:0] gv;
    logic [1:0]  m_ptr;
    logic [7:0]  m_conf;
    logic [11:0] m_tlow, m_thigh;

    vecs[0] = '{"ptr0_rd2",  DEV,      1, 8'h00, 8'h00, 8'h00, 2, 12'h19A, 1'b1, 8'h19, 8'hA0, 8'h00, 12'h500, 1};
    vecs[1] = '{"wrong_adr", 7'h4D,    2, 8'h01, 8'hFF, 8'h00, 0, 12'h19A, 1'b0, 8'h00, 8'h00, 8'h00, 12'h500, 0};
    vecs[2] = '{"conf_wr",   DEV,      2, 8'h01, 8'h60, 8'h00, 0, 12'h19A, 1'b1, 8'h00, 8'h00, 8'h60, 12'h500, 1};
    vecs[3] = '{"conf_rd",   DEV,      0, 8'h00, 8'h00, 8'h00, 1, 12'h19A, 1'b1, 8'h60, 8'h00, 8'h60, 12'h500, 1};
    vecs[4] = '{"thigh_wr",  DEV,      3, 8'h03, 8'h5A, 8'h30, 0, 12'h19A, 1'b1, 8'h00, 8'h00, 8'h60, 12'h5A3, 1};
    vecs[5] = '{"thigh_rd",  DEV,      1, 8'h03, 8'h00, 8'h00, 2, 12'h19A, 1'b1, 8'h5A, 8'h30, 8'h60, 12'h5A3, 1};

    reset_n = 1'b0;
    ena = 1'b1;
    temperature = 12'h000;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sda_t", sda_t, 1'b1);
    check("rst_scl_t", scl_t, 1'b1);
    check("rst_pointer", pointer, 2'd0);
    check("rst_config", config_reg, 8'h00);
    check("rst_tlow", tlow, 12'h4B0);
    check("rst_thigh", thigh, 12'h500);
    check("rst_status", status, 3'b000);

    for (int v = 0; v < 6; v++) begin
      wbuf[0] = vecs[v].w0;
      wbuf[1] = vecs[v].w1;
      wbuf[2] = vecs[v].w2;
      temperature = vecs[v].temp;
      d0 = done_total; l0 = low_total; s0 = sel_total;
      xfer(vecs[v].addr, vecs[v].nw, vecs[v].nr);
      check({vecs[v].name, "_addr_ack"}, addr_ack, vecs[v].exp_ack);
      if (vecs[v].exp_ack) check({vecs[v].name, "_data_ack"}, bytes_acked, 1'b1);
      if (vecs[v].nr >= 1) check({vecs[v].name, "_r0"}, rbuf[0], vecs[v].exp_r0);
      if (vecs[v].nr >= 2) check({vecs[v].name, "_r1"}, rbuf[1], vecs[v].exp_r1);
      check({vecs[v].name, "_config"}, config_reg, vecs[v].exp_conf);
      check({vecs[v].name, "_thigh"}, thigh, vecs[v].exp_thigh);
      check({vecs[v].name, "_done"}, done_total - d0, vecs[v].exp_done);
      if (!vecs[v].exp_ack) begin
        check({vecs[v].name, "_sda_low"}, low_total - l0, 0);
        check({vecs[v].name, "_selected"}, sel_total - s0, 0);
      end
    end

    // Temperature changes while the MSB is on the wire; LSB must come from
    // the value captured with the MSB.
    wbuf[0] = 8'h00;
    temperature = 12'h19A;
    swap_armed = 1'b1;
    xfer(DEV, 1, 2);
    check("snap_ack", addr_ack, 1'b1);
    check("snap_msb", rbuf[0], 8'h19);
    check("snap_lsb", rbuf[1], 8'hA0);

    // One-clk SCL glitch during the low phase of a data bit.
    gv = 8'h12;
    i2c_start();
    write_byte({DEV, 1'b0}, nk);
    check("glitch_addr_ack", nk, 1'b0);
    write_byte(8'h02, nk);
    for (int i = 7; i >= 0; i--) write_bit(gv[i], i == 3);
    read_bit(nk);
    check("glitch_msb_ack", nk, 1'b0);
    write_byte(8'h30, nk);
    i2c_stop();
    wait_q();
    check("glitch_tlow", tlow, 12'h123);

    // Reset while the target is pulling SDA low during a read.
    temperature = 12'h19A;
    i2c_start();
    write_byte({DEV, 1'b0}, nk);
    write_byte(8'h00, nk);
    i2c_start();
    write_byte({DEV, 1'b1}, nk);
    check("rstmid_addr_ack", nk, 1'b0);
    for (int i = 0; i < 40 && sda_t; i++) @(negedge clk);
    check("rstmid_sda_low_before", sda_t, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_sda_t", sda_t, 1'b1);
    check("rstmid_config", config_reg, 8'h00);
    check("rstmid_tlow", tlow, 12'h4B0);
    check("rstmid_thigh", thigh, 12'h500);
    check("rstmid_pointer", pointer, 2'd0);
    check("rstmid_status", status, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q(); wait_q();
    wbuf[0] = 8'h00;
    d0 = done_total;
    xfer(DEV, 1, 2);
    check("post_rst_ack", addr_ack, 1'b1);
    check("post_rst_r0", rbuf[0], 8'h19);
    check("post_rst_r1", rbuf[1], 8'hA0);
    check("post_rst_done", done_total - d0, 1);

    // Randomized transactions against the reference model.
    m_ptr = 2'd0; m_conf = 8'h00; m_tlow = 12'h4B0; m_thigh = 12'h500;
    for (int t = 0; t < 16; t++) begin
      logic       hit;
      logic [6:0] a7;
      logic [7:0] expb;
      int         nw, nr;
      ena = ($urandom_range(0, 5) != 0);
      a7  = ($urandom_range(0, 3) != 0) ? DEV : 7'($urandom_range(0, 127));
      nw  = $urandom_range(1, 3);
      nr  = $urandom_range(0, 2);
      for (int j = 0; j < nw; j++) wbuf[j] = 8'($urandom);
      temperature = 12'($urandom);
      hit = ena && (a7 == DEV);
      d0 = done_total;
      xfer(a7, nw, nr);
      ena = 1'b1;
      if (hit) begin
        m_ptr = wbuf[0][1:0];
        for (int k = 0; k < nw - 1; k++) begin
          case (m_ptr)
            2'd1: m_conf  = wbuf[k+1];
            2'd2: m_tlow  = img_write(m_tlow, k, wbuf[k+1]);
            2'd3: m_thigh = img_write(m_thigh, k, wbuf[k+1]);
            default: ;
          endcase
        end
      end
      check("rnd_addr_ack", addr_ack, hit);
      if (hit) begin
        check("rnd_data_ack", bytes_acked, 1'b1);
        for (int i = 0; i < nr; i++) begin
          case (m_ptr)
            2'd0:    expb = img_byte(temperature, i);
            2'd1:    expb = m_conf;
            2'd2:    expb = img_byte(m_tlow, i);
            default: expb = img_byte(m_thigh, i);
          endcase
          check("rnd_rdata", rbuf[i], expb);
        end
      end
      check("rnd_done", done_total - d0, hit ? 1 : 0);
      check("rnd_pointer", pointer, m_ptr);
      check("rnd_config", config_reg, m_conf);
      check("rnd_tlow", tlow, m_tlow);
      check("rnd_thigh", thigh, m_thigh);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
